mult_div_ctrl: RTL and testbench
================================

MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width and iteration count (fixed at 32 for MIPS use).
REQ-002 SHALL have port: clk  input  1  clock, all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request from control unit, sampled on the rising edge.
REQ-005 SHALL have port: op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port: a  input  WIDTH  rs operand (multiplicand or dividend).
REQ-007 SHALL have port: b  input  WIDTH  rt operand (multiplier or divisor).
REQ-008 SHALL have port: busy  output  1  operation in progress.
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: hi  output  WIDTH  HI register (product upper half or remainder).
REQ-011 SHALL have port: lo  output  WIDTH  LO register (product lower half or quotient).
REQ-012 SHALL have port: div_zero  output  1  last DIV/DIVU had b==0.

Function
REQ-013 SHALL implement states IDLE, PREP, MUL, DIV, FIX, DONE.
REQ-014 IDLE or DONE with start=1 SHALL latch op, a, b and go to PREP; later input changes are ignored.
REQ-015 start while busy=1 SHALL be ignored, with no effect on the running operation.
REQ-016 PREP SHALL take absolute values for signed ops, record result signs, clear the iteration counter, then go to MUL (op[1]=0) or DIV (op[1]=1).
REQ-017 MUL SHALL run one shift-add step per cycle for exactly WIDTH cycles, then go to FIX.
REQ-018 DIV SHALL run one restoring shift-subtract step per cycle for exactly WIDTH cycles, then go to FIX.
REQ-019 FIX SHALL apply sign correction and write hi/lo, then go to DONE.
REQ-020 MULT/MULTU SHALL give {hi,lo} = the full 2*WIDTH-bit signed/unsigned product.
REQ-021 DIV/DIVU SHALL give lo = quotient truncated toward zero and hi = remainder with the sign of the dividend.
REQ-022 DIV with a=0x80000000 and b=0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-023 Any division with b==0 SHALL give hi=a, lo=all-ones.
REQ-024 Latency: with start sampled at edge E, done SHALL be high for exactly the cycle after edge E+WIDTH+3 (E+35).
REQ-025 hi/lo SHALL update at edge E+WIDTH+2 and hold until the next FIX state or reset.
REQ-026 busy SHALL be 1 from edge E+1 until done rises, and 0 while done=1.
REQ-027 div_zero SHALL update only at completion, and be cleared at completion of any op without b==0.

Reset
REQ-028 rst=0 SHALL immediately force state IDLE, counter 0, busy=0, done=0, div_zero=0, hi=0, lo=0, independent of clk.
REQ-029 Reset mid-operation SHALL abandon the operation without partial hi/lo update.
REQ-030 The first start after rst returns to 1 SHALL be accepted normally.

Configuration
REQ-031 Macro MULT_DIV_ZERO_FAST_EN defined: a division with b==0 SHALL go PREP -> FIX -> DONE, with done after edge E+3 and div_zero=1.
REQ-032 Macro undefined: a division with b==0 SHALL run full latency with results per REQ-023, and div_zero SHALL be constant 0.

Verification
REQ-033 MULT a=0xFFFFFFFE, b=0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA, done after edge E+35 for one cycle.
REQ-034 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 DIV a=0xFFFFFFF9 (-7), b=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU same operands -> lo=0x7FFFFFFC, hi=0x00000001.
REQ-036 DIVU a=100, b=0 -> hi=100, lo=0xFFFFFFFF; with macro: done after E+3 and div_zero=1; without macro: done after E+35 and div_zero=0.
REQ-037 MULT started, rst=0 pulsed mid-cycle at E+10 -> all outputs 0 immediately; new MULTU 5*6 -> lo=30, hi=0 after 35 edges.
REQ-038 start re-pulsed and a/b changed during busy -> ignored, original result delivered; start during the done cycle -> accepted with busy=1 next cycle.

Source files
------------

// File: rtl/mult_div_ctrl.sv
// Iterative MIPS multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Build option MULT_DIV_ZERO_FAST_EN: divide-by-zero skips the iterations and raises div_zero.

module mult_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_t;

  state_t             r_state;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic               w_b_zero;
  logic               w_last;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_signed = ~r_op[0];
  assign w_b_zero = (r_b == '0);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_abs_a  = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_abs_b  = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;

  // r_prod holds {upper, lower} for multiply and {remainder, quotient} for divide.
  assign w_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_shift = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_mcand});
  assign w_diff  = w_shift[WIDTH-1:0] - r_mcand;

  assign w_prod_fix = r_neg_q ? -r_prod : r_prod;
  assign w_quo_fix  = r_neg_q ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
  assign w_rem_fix  = r_neg_r ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];

`ifdef MULT_DIV_ZERO_FAST_EN
  logic r_div_zero;
  assign div_zero = r_div_zero;
`else
  assign div_zero = 1'b0;
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
`ifdef MULT_DIV_ZERO_FAST_EN
      r_div_zero <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_a     <= a;
            r_b     <= b;
            r_busy  <= 1'b1;
            r_state <= ST_PREP;
          end
        end
        ST_PREP: begin
          r_mcand <= w_abs_b;
          r_prod  <= {{WIDTH{1'b0}}, w_abs_a};
          r_neg_q <= w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_neg_r <= w_signed && r_a[WIDTH-1];
          r_cnt   <= '0;
          if (!r_op[1]) begin
            r_state <= ST_MUL;
          end else begin
`ifdef MULT_DIV_ZERO_FAST_EN
            r_state <= w_b_zero ? ST_FIX : ST_DIV;
`else
            r_state <= ST_DIV;
`endif
          end
        end
        ST_MUL: begin
          r_prod <= {w_sum, r_prod[WIDTH-1:1]};
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) r_state <= ST_FIX;
        end
        ST_DIV: begin
          r_prod <= {(w_ge ? w_diff : w_shift[WIDTH-1:0]), r_prod[WIDTH-2:0], w_ge};
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) r_state <= ST_FIX;
        end
        ST_FIX: begin
          if (r_op[1] && w_b_zero) begin
            r_hi <= r_a;
            r_lo <= '1;
          end else if (r_op[1]) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
          end
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
`ifdef MULT_DIV_ZERO_FAST_EN
          r_div_zero <= r_op[1] && w_b_zero;
`endif
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: arithmetic reference model compared every cycle,
// plus hand-computed literal cases and randomized start/operand traffic.

module tb_mult_div_ctrl;

`ifdef MULT_DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int LAT_FULL = 35;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int n_pass  = 0;
  int n_total = 0;

  mult_div_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference arithmetic straight from the MIPS definitions, using 64-bit integers.
  function automatic void model_calc(input logic [1:0] o, input logic [31:0] x,
                                     input logic [31:0] y,
                                     output logic [31:0] h, output logic [31:0] l);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    q = 0;
    r = 0;
    p = '0;
    if (o[1] && y == 32'd0) begin
      p = {x, 32'hFFFF_FFFF};
    end else begin
      case (o)
        2'd0: p = 64'(sx * sy);
        2'd1: p = {32'd0, x} * {32'd0, y};
        2'd2: begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
        default: p = {x % y, x / y};
      endcase
    end
    h = p[63:32];
    l = p[31:0];
  endfunction

  // Model state: the accepted operation and its expected timeline, counted in clock edges.
  int          edge_n = 0;
  int          e_edge = 0;
  int          m_lat  = LAT_FULL;
  bit          have_op = 1'b0;
  logic [31:0] res_hi = '0, res_lo = '0, cur_hi = '0, cur_lo = '0;
  logic        res_dz = 1'b0, cur_dz = 1'b0;

  always @(negedge rst) begin
    have_op = 1'b0;
    cur_hi  = '0;
    cur_lo  = '0;
    cur_dz  = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      edge_n++;
      if (start && !(have_op && (edge_n - 1) < e_edge + m_lat)) begin
        have_op = 1'b1;
        e_edge  = edge_n;
        model_calc(op, a, b, res_hi, res_lo);
        res_dz  = FAST && op[1] && (b == 32'd0);
        m_lat   = res_dz ? 3 : LAT_FULL;
      end
      if (have_op && edge_n == e_edge + m_lat - 1) begin
        cur_hi = res_hi;
        cur_lo = res_lo;
      end
      if (have_op && edge_n == e_edge + m_lat) cur_dz = res_dz;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("busy", busy, have_op && edge_n < e_edge + m_lat);
      check("done", done, have_op && edge_n == e_edge + m_lat);
      check("hi", hi, cur_hi);
      check("lo", lo, cur_lo);
      check("div_zero", div_zero, cur_dz);
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called just after the accepting edge; scrambles inputs while busy and checks the result.
  task automatic finish_lit(input string name, input logic [31:0] eh, input logic [31:0] el,
                            input int elat, input bit junk);
    int n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      start = junk && (n == 5 || n == 12);
      op    = 2'($urandom_range(3));
      a     = $urandom;
      b     = $urandom;
    end
    start = 1'b0;
    check({name, "_lat"}, 64'(n), 64'(elat));
    check({name, "_hi"}, hi, eh);
    check({name, "_lo"}, lo, el);
  endtask

  task automatic run_lit(input string name, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                         input int elat, input bit junk);
    issue(o, x, y);
    finish_lit(name, eh, el, elat, junk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 64'(busy || done), 64'd0);
  endtask

  task automatic check_zero(input string name);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_done"}, done, 1'b0);
    check({name, "_hi"}, hi, 32'd0);
    check({name, "_lo"}, lo, 32'd0);
    check({name, "_dz"}, div_zero, 1'b0);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    op    = 2'd0;
    a     = '0;
    b     = '0;
    #1;
    check_zero("reset");
    #11 rst = 1'b1;

    run_lit("mult_neg", 2'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 35, 1'b1);
    run_lit("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 35, 1'b0);
    run_lit("div_neg", 2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 35, 1'b1);

    // Start during the done cycle must be accepted at once.
    op    = 2'd3;
    a     = 32'hFFFF_FFF9;
    b     = 32'h0000_0002;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_cycle_start_busy", busy, 1'b1);
    finish_lit("divu", 32'h0000_0001, 32'h7FFF_FFFC, 35, 1'b0);

    run_lit("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 35, 1'b0);
    run_lit("divu_zero", 2'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, FAST ? 3 : 35, 1'b0);
    check("divu_zero_flag", div_zero, FAST);
    run_lit("div_zero_s", 2'd2, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, FAST ? 3 : 35, 1'b0);
    run_lit("mult_small", 2'd0, 32'd3, 32'd4, 32'd0, 32'd12, 35, 1'b0);
    check("dz_cleared", div_zero, 1'b0);

    // Asynchronous reset in the middle of an operation.
    issue(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(posedge clk);
    check("pre_reset_busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1 check_zero("mid_reset");
    #1 rst = 1'b1;
    run_lit("post_reset", 2'd1, 32'd5, 32'd6, 32'd0, 32'd30, 35, 1'b0);

    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      start = ($urandom_range(7) == 0);
      op    = 2'($urandom_range(3));
      a     = pick();
      b     = pick();
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
